// File: rtl/bank_readout_pkg.sv
// Shared definitions for the parameter-bank readout path: bank geometry
// defaults and the readout FSM state encoding. The pipe-in bank combiner
// uses the same geometry.
// Optional feature macro: BANK_READOUT_CHECKSUM_EN adds a trailing checksum word.
package bank_readout_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int WORDS_DEF = 64;
    localparam int IDX_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1
`ifdef BANK_READOUT_CHECKSUM_EN
        ,
        ST_CSUM = 2'd2
`endif
    } state_t;

endpackage

// File: rtl/bank_readout_word_mux.sv
// Word selector: picks word[sel] out of the flattened shadow bank.
module word_mux
    import bank_readout_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic [WIDTH*WORDS-1:0] bank_in,
    input  logic [IDX_W-1:0]       sel,
    output logic [WIDTH-1:0]       word
);

    assign word = bank_in[WIDTH*sel +: WIDTH];

endmodule

// File: rtl/bank_readout.sv
// Snapshot a parameter bank on start and stream it out word by word as a
// first-word-fall-through source for a pipe-out endpoint.
// Optional feature macro: BANK_READOUT_CHECKSUM_EN appends a mod-2^WIDTH sum
// of all words as one extra word before the readout completes.
module bank_readout
    import bank_readout_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WIDTH*WORDS-1:0] bank,
    input  logic                   rd,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   busy,
    output logic                   done,
    output logic [IDX_W-1:0]       index,
    output logic                   underrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t                 state_r, state_s;
    logic [WIDTH*WORDS-1:0] shadow_r;
    logic [IDX_W-1:0]       index_r, index_s;
    logic                   load_s;
    logic                   done_r, done_s;
    logic                   underrun_r, underrun_s;
    logic [WIDTH-1:0]       word_s;
`ifdef BANK_READOUT_CHECKSUM_EN
    logic [WIDTH-1:0]       sum_r, sum_s;
`endif

    word_mux #(
        .WIDTH (WIDTH),
        .WORDS (WORDS)
    ) u_word_mux (
        .bank_in (shadow_r),
        .sel     (index_r),
        .word    (word_s)
    );

    // Next-state logic: start acceptance, word advance, completion and underrun.
    always_comb begin
        state_s    = state_r;
        index_s    = index_r;
        load_s     = 1'b0;
        done_s     = 1'b0;
        underrun_s = underrun_r;
`ifdef BANK_READOUT_CHECKSUM_EN
        sum_s      = sum_r;
`endif
        case (state_r)
            ST_IDLE: begin
                index_s = {IDX_W{1'b0}};
                if (start) begin
                    // A rd landing together with start still counts as an underrun.
                    state_s    = ST_SEND;
                    load_s     = 1'b1;
                    underrun_s = rd;
`ifdef BANK_READOUT_CHECKSUM_EN
                    sum_s      = {WIDTH{1'b0}};
`endif
                end else if (rd) begin
                    underrun_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (rd) begin
`ifdef BANK_READOUT_CHECKSUM_EN
                    sum_s = sum_r + word_s;
`endif
                    if (index_r == LAST_IDX) begin
`ifdef BANK_READOUT_CHECKSUM_EN
                        // Hold index on the last word while the sum is presented.
                        state_s = ST_CSUM;
`else
                        state_s = ST_IDLE;
                        index_s = {IDX_W{1'b0}};
                        done_s  = 1'b1;
`endif
                    end else begin
                        index_s = index_r + 6'd1;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
`ifdef BANK_READOUT_CHECKSUM_EN
            ST_CSUM: begin
                if (rd) begin
                    state_s = ST_IDLE;
                    index_s = {IDX_W{1'b0}};
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_CSUM;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
                index_s = {IDX_W{1'b0}};
            end
        endcase
    end

    // State, shadow bank and flag registers; reset abandons any readout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            index_r    <= {IDX_W{1'b0}};
            shadow_r   <= {(WIDTH*WORDS){1'b0}};
            done_r     <= 1'b0;
            underrun_r <= 1'b0;
`ifdef BANK_READOUT_CHECKSUM_EN
            sum_r      <= {WIDTH{1'b0}};
`endif
        end else begin
            state_r    <= state_s;
            index_r    <= index_s;
            done_r     <= done_s;
            underrun_r <= underrun_s;
`ifdef BANK_READOUT_CHECKSUM_EN
            sum_r      <= sum_s;
`endif
            if (load_s) begin
                shadow_r <= bank;
            end
        end
    end

    // Output word: zero when idle, shadow word while sending, sum in CSUM.
    always_comb begin
        dout = {WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: dout = {WIDTH{1'b0}};
            ST_SEND: dout = word_s;
`ifdef BANK_READOUT_CHECKSUM_EN
            ST_CSUM: dout = sum_r;
`endif
            default: dout = {WIDTH{1'b0}};
        endcase
    end

    assign empty    = (state_r == ST_IDLE);
    assign busy     = (state_r != ST_IDLE);
    assign done     = done_r;
    assign index    = index_r;
    assign underrun = underrun_r;

endmodule

// File: tb/tb_bank_readout.sv
// Directed self-checking bench for bank_readout. Checksum expectations are
// compiled in when BANK_READOUT_CHECKSUM_EN is defined.
module tb_bank_readout;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1023:0] bank;
    logic          rd;
    logic [15:0]   dout;
    logic          empty;
    logic          busy;
    logic          done;
    logic [5:0]    index;
    logic          underrun;

    int checks = 0;
    int errors = 0;

    bank_readout dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bank     (bank),
        .rd       (rd),
        .dout     (dout),
        .empty    (empty),
        .busy     (busy),
        .done     (done),
        .index    (index),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bank_seq();
        for (int k = 0; k < 64; k++) begin
            bank[16*k +: 16] = 16'h0100 + 16'(k);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // reset and start together: reset wins
        reset = 1'b1; start = 1'b1; rd = 1'b0; bank = '0;
        cyc(); cyc();
        reset = 1'b0; start = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL reset_dout got %h exp 0000", dout); end
        checks++; if (index !== 6'd0) begin errors++; $display("FAIL reset_index got %0d exp 0", index); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b exp 0", underrun); end
        cyc();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_start_prio got empty %b exp 1", empty); end
    endtask

    task automatic test_full_readout();
        logic [15:0] exp_w;
        set_bank_seq();
        start = 1'b1; cyc(); start = 1'b0;
        checks++; if (busy !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL full_busy got busy %b empty %b exp 1 0", busy, empty); end
        for (int k = 0; k < 64; k++) begin
            exp_w = 16'h0100 + 16'(k);
            checks++; if (dout !== exp_w) begin errors++; $display("FAIL full_dout[%0d] got %h exp %h", k, dout, exp_w); end
            checks++; if (index !== 6'(k)) begin errors++; $display("FAIL full_index[%0d] got %0d exp %0d", k, index, k); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_early_done[%0d] got %b exp 0", k, done); end
            rd = 1'b1; cyc();
        end
        rd = 1'b0;
`ifdef BANK_READOUT_CHECKSUM_EN
        checks++; if (dout !== 16'h47E0) begin errors++; $display("FAIL csum_dout got %h exp 47e0", dout); end
        checks++; if (index !== 6'd63) begin errors++; $display("FAIL csum_index got %0d exp 63", index); end
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL csum_state got done %b busy %b exp 0 1", done, busy); end
        rd = 1'b1; cyc(); rd = 1'b0;
`endif
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done got %b exp 1", done); end
        checks++; if (empty !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL full_end got empty %b busy %b exp 1 0", empty, busy); end
        checks++; if (dout !== 16'h0000 || index !== 6'd0) begin errors++; $display("FAIL full_idle got dout %h index %0d exp 0000 0", dout, index); end
        cyc();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_once got %b exp 0", done); end
    endtask

    task automatic test_snapshot();
        logic [15:0] exp_w;
        set_bank_seq();
        start = 1'b1; cyc(); start = 1'b0;
        bank = {64{16'hFFFF}};
        for (int k = 0; k < 64; k++) begin
            exp_w = 16'h0100 + 16'(k);
            checks++; if (dout !== exp_w) begin errors++; $display("FAIL snap_dout[%0d] got %h exp %h", k, dout, exp_w); end
            rd = 1'b1; cyc();
        end
        rd = 1'b0;
`ifdef BANK_READOUT_CHECKSUM_EN
        checks++; if (dout !== 16'h47E0) begin errors++; $display("FAIL snap_csum got %h exp 47e0", dout); end
        rd = 1'b1; cyc(); rd = 1'b0;
`endif
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL snap_done got %b exp 1", done); end
        cyc();
    endtask

    task automatic test_underrun();
        rd = 1'b1; cyc(); rd = 1'b0;
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_idle got %b exp 1", underrun); end
        checks++; if (empty !== 1'b1 || dout !== 16'h0000 || index !== 6'd0) begin errors++; $display("FAIL underrun_nostate got empty %b dout %h index %0d exp 1 0000 0", empty, dout, index); end
        set_bank_seq();
        start = 1'b1; rd = 1'b1; cyc(); start = 1'b0; rd = 1'b0;
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_start_rd got %b exp 1", underrun); end
        checks++; if (dout !== 16'h0100 || index !== 6'd0) begin errors++; $display("FAIL underrun_first got dout %h index %0d exp 0100 0", dout, index); end
        for (int k = 0; k < 64; k++) begin
            rd = 1'b1; cyc();
        end
`ifdef BANK_READOUT_CHECKSUM_EN
        cyc();
`endif
        rd = 1'b0;
        cyc();
        checks++; if (underrun !== 1'b1 || empty !== 1'b1) begin errors++; $display("FAIL underrun_sticky got %b empty %b exp 1 1", underrun, empty); end
        start = 1'b1; cyc(); start = 1'b0;
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear got %b exp 0", underrun); end
        checks++; if (dout !== 16'h0100) begin errors++; $display("FAIL underrun_restart got %h exp 0100", dout); end
        do_reset();
    endtask

    task automatic test_reset_abort();
        set_bank_seq();
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rd = 1'b1; cyc();
        end
        rd = 1'b0;
        checks++; if (dout !== 16'h010A || index !== 6'd10) begin errors++; $display("FAIL abort_pre got dout %h index %0d exp 010a 10", dout, index); end
        reset = 1'b1; cyc(); reset = 1'b0;
        checks++; if (empty !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle got empty %b busy %b exp 1 0", empty, busy); end
        checks++; if (dout !== 16'h0000 || index !== 6'd0) begin errors++; $display("FAIL abort_out got dout %h index %0d exp 0000 0", dout, index); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", done); end
        cyc();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done_late got %b exp 0", done); end
        start = 1'b1; cyc(); start = 1'b0;
        checks++; if (dout !== 16'h0100 || index !== 6'd0) begin errors++; $display("FAIL abort_restart got dout %h index %0d exp 0100 0", dout, index); end
        do_reset();
    endtask

    task automatic test_start_ignored();
        logic [15:0] exp_w;
        set_bank_seq();
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rd = 1'b1; cyc();
        end
        rd = 1'b0;
        checks++; if (dout !== 16'h0105 || index !== 6'd5) begin errors++; $display("FAIL ignore_pre got dout %h index %0d exp 0105 5", dout, index); end
        bank = {64{16'hFFFF}};
        start = 1'b1; rd = 1'b1; cyc(); start = 1'b0; rd = 1'b0;
        for (int k = 6; k < 64; k++) begin
            exp_w = 16'h0100 + 16'(k);
            checks++; if (dout !== exp_w || index !== 6'(k)) begin errors++; $display("FAIL ignore_seq[%0d] got dout %h index %0d exp %h %0d", k, dout, index, exp_w, k); end
            rd = 1'b1; cyc();
        end
        rd = 1'b0;
`ifdef BANK_READOUT_CHECKSUM_EN
        checks++; if (dout !== 16'h47E0) begin errors++; $display("FAIL ignore_csum got %h exp 47e0", dout); end
        rd = 1'b1; cyc(); rd = 1'b0;
`endif
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ignore_done got %b exp 1", done); end
        cyc();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; rd = 1'b0; bank = '0;
        test_reset();
        test_full_readout();
        test_snapshot();
        test_underrun();
        test_reset_abort();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
